// File: rtl/field_scan_ctrl.sv
// -----------------------------------------------------------------------------
// field_scan_ctrl
//
// Sequencer for the 3-bit field selector datapath. A 16-bit word is accepted
// on a valid/ready handshake. A programmable run of its 3-bit fields is then
// emitted one per beat, starting at a given field index and wrapping modulo
// NUM_FIELDS. Output beats obey valid/ready backpressure.
//
// Ports
//   i_clk    in   clock, rising edge
//   i_rst    in   asynchronous reset, active low
//   i_clr    in   synchronous abort: drop the held word, return to IDLE
//   i_data   in   [DATA_W-1:0]  input word
//   i_valid  in   i_data / i_first / i_count valid
//   o_ready  out  block can accept a word (IDLE, not in first post-reset cycle)
//   i_first  in   [SEL_W-1:0]   first field index for this word
//   i_count  in   [SEL_W:0]     fields to emit (0 -> NUM_FIELDS, saturating)
//   o_data   out  [FIELD_W-1:0] current field
//   o_sel    out  [SEL_W-1:0]   index of current field
//   o_valid  out  o_data / o_sel / o_last valid
//   i_ready  in   downstream accepts the beat
//   o_last   out  current beat is the final one for this word
//   o_busy   out  a word is held (EMIT state)
// -----------------------------------------------------------------------------
module field_scan_ctrl #(
    parameter int DATA_W     = 16,
    parameter int FIELD_W    = 3,
    parameter int NUM_FIELDS = 4,
    parameter int BASE_LSB   = 2,
    parameter int SEL_W      = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clr,
    input  logic [DATA_W-1:0]  i_data,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [SEL_W-1:0]   i_first,
    input  logic [SEL_W:0]     i_count,
    output logic [FIELD_W-1:0] o_data,
    output logic [SEL_W-1:0]   o_sel,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_last,
    output logic               o_busy
);

    // Only the bits covered by the fields are ever selected, so only that
    // span of the word is held.
    localparam int SPAN_W = NUM_FIELDS * FIELD_W;
    localparam logic [SEL_W:0] FULL_COUNT = (SEL_W + 1)'(NUM_FIELDS);
    localparam logic [SEL_W:0] ONE_COUNT  = (SEL_W + 1)'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t             state_reg,     state_next;
    logic [SPAN_W-1:0]  word_reg,      word_next;
    logic [SEL_W-1:0]   sel_reg,       sel_next;
    logic [SEL_W:0]     remaining_reg, remaining_next;
    // Cleared by reset, set on the first edge after release. Keeps o_ready low
    // for that first cycle so no word can be captured on the release edge.
    logic               armed_reg;

    logic               emit;
    logic               ready;
    logic               last;
    logic [SEL_W:0]     eff_count;
    logic [FIELD_W-1:0] field_arr [NUM_FIELDS];

    // Bits of i_data outside the field span are intentionally ignored.
    logic               unused_data;
    assign unused_data = ^i_data;

    // -------------------------------------------------------------------------
    // Field slicing of the held word
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
            assign field_arr[gi] = word_reg[gi*FIELD_W +: FIELD_W];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Decoded status
    // -------------------------------------------------------------------------
    assign emit  = (state_reg == ST_EMIT);
    assign ready = (state_reg == ST_IDLE) && armed_reg;
    assign last  = emit && (remaining_reg == ONE_COUNT);

    // A count of zero requests a full scan; anything larger than the number of
    // fields is clipped to a full scan as well.
    always_comb begin
        eff_count = i_count;
        if ((i_count == '0) || (i_count > FULL_COUNT)) begin
            eff_count = FULL_COUNT;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg     <= ST_IDLE;
            word_reg      <= '0;
            sel_reg       <= '0;
            remaining_reg <= '0;
            armed_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            word_reg      <= word_next;
            sel_reg       <= sel_next;
            remaining_reg <= remaining_next;
            armed_reg     <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        word_next      = word_reg;
        sel_next       = sel_reg;
        remaining_next = remaining_reg;

        if (i_clr) begin
            // Abort wins over any capture or beat transfer on the same edge.
            state_next     = ST_IDLE;
            word_next      = '0;
            sel_next       = '0;
            remaining_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_valid && ready) begin
                        state_next     = ST_EMIT;
                        word_next      = i_data[BASE_LSB +: SPAN_W];
                        sel_next       = i_first;
                        remaining_next = eff_count;
                    end
                end
                ST_EMIT: begin
                    if (i_ready) begin
                        if (last) begin
                            state_next     = ST_IDLE;
                            remaining_next = '0;
                        end else begin
                            // NUM_FIELDS is a power of two, so the natural
                            // wrap of the index gives the modulo step.
                            sel_next       = sel_reg + 1'b1;
                            remaining_next = remaining_reg - ONE_COUNT;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs, all decoded from registers. Beat fields are forced to zero
    // outside EMIT so idle outputs never show stale data.
    // -------------------------------------------------------------------------
    assign o_ready = ready;
    assign o_valid = emit;
    assign o_busy  = emit;
    assign o_last  = last;
    assign o_data  = emit ? field_arr[sel_reg] : '0;
    assign o_sel   = emit ? sel_reg : '0;

endmodule
